multicycle_ctrl: RTL and testbench

- Multicycle control unit for the 32-bit ARM-like CPU. Sits directly upstream of the ALU.
- Decodes the latched instruction fields and sequences each instruction through a Moore FSM.
- Drives ALUControl and the datapath mux selects and write enables.
- Holds the architectural NZCV flag register, loaded from the ALU flag outputs, and evaluates ARM condition codes.

---
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: Moore sequencer, ALU/flag-write decode, NZCV flag
// register and ARM condition evaluation feeding the datapath enables.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;
    logic       r_cond_ex;

    logic [3:0] w_cmd;
    logic       w_cmp, w_known, w_arith, w_set;
    logic       w_alu_op, w_cond_ex, w_cond_use, w_suppress;
    logic [1:0] w_flag_w;
    logic       w_next_pc, w_branch, w_reg_w, w_mem_w, w_ir_write, w_pcs;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_cmd    = Funct[4:1];
    assign w_cmp    = (w_cmd == 4'b1010);
    assign w_known  = (w_cmd == 4'b0100) | (w_cmd == 4'b0010) |
                      (w_cmd == 4'b0000) | (w_cmd == 4'b1100);
    assign w_arith  = (w_cmd == 4'b0100) | (w_cmd == 4'b0010) | w_cmp;
    assign w_set    = Funct[0] | w_cmp;
    assign w_alu_op = (r_state == S_EXECUTER) | (r_state == S_EXECUTEI);
    assign w_flag_w = {w_alu_op & w_set, w_alu_op & w_set & w_arith};

    always_comb begin
        ALUControl = 2'b00;
        if (w_alu_op) begin
            case (w_cmd)
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                4'b1010: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_next_pc  = 1'b0;
        w_branch   = 1'b0;
        w_reg_w    = 1'b0;
        w_mem_w    = 1'b0;
        w_ir_write = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'd0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_next_pc  = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                ResultSrc  = 2'd2;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                case (Op)
                    2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'd1;
                w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'd1;
                w_reg_w   = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                w_mem_w = 1'b1;
            end
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: begin
                ALUSrcB = 2'd1;
                w_next  = S_ALUWB;
            end
            S_ALUWB: w_reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                w_branch  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Flags were already rewritten when ALUWB is reached, so writeback uses the
    // condition captured in execute; a suppressed result also never reaches PC.
    assign w_cond_use = (r_state == S_ALUWB) ? r_cond_ex : w_cond_ex;
    assign w_suppress = (r_state == S_ALUWB) & ~w_known;
    assign w_pcs      = w_branch | (w_reg_w & ~w_suppress & (Rd == 4'hF));

    assign PCWrite  = rst_n & (w_next_pc | (w_pcs & w_cond_use));
    assign RegWrite = rst_n & w_reg_w & ~w_suppress & w_cond_use;
    assign MemWrite = rst_n & w_mem_w & w_cond_use;
    assign IRWrite  = rst_n & w_ir_write;

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign Flags  = r_flags;
    assign State  = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_flags   <= RESET_FLAGS;
            r_cond_ex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_alu_op) begin
                r_cond_ex <= w_cond_ex;
                if (w_cond_ex && w_flag_w[1]) r_flags[3:2] <= ALUFlags[3:2];
                if (w_cond_ex && w_flag_w[0]) r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference model with a per-cycle
// compare process, directed literal checks and randomized instruction streams.
module tb_multicycle_ctrl;
  localparam int W = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] Cond = '0;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;
  logic [3:0] ALUFlags = '0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags, State;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

  // Packed view: {state, flags, aluctl, srcb, srca, result, adr, pcw, irw, memw, regw, imm, regsrc}
  logic [W-1:0] dut_vec;
  assign dut_vec = {State, Flags, ALUControl, ALUSrcB, ALUSrcA, ResultSrc, AdrSrc,
                    PCWrite, IRWrite, MemWrite, RegWrite, ImmSrc, RegSrc};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  logic [3:0]   m_flags = 4'b0000;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] pack(input logic [3:0] st, input logic [3:0] fl,
                                        input logic [1:0] ctl, input logic [1:0] srcb,
                                        input logic srca, input logic [1:0] res,
                                        input logic adr, input logic pcw, input logic irw,
                                        input logic memw, input logic regw,
                                        input logic [1:0] op);
    logic [1:0] rsrc;
    rsrc = {op == 2'b01, op == 2'b10};
    return {st, fl, ctl, srcb, srca, res, adr, pcw, irw, memw, regw, op, rsrc};
  endfunction

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected per-cycle outputs of one whole instruction; advances the model flags.
  task automatic model_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af, output int n);
    logic       ok, wr15, known, cmp, arith, s;
    logic [3:0] fl, nf, cmd;
    logic [1:0] ctl;
    fl   = m_flags;
    ok   = cond_holds(c, fl);
    wr15 = (r == 4'hF);
    cmd  = f[4:1];
    exp_q.push_back(pack(4'd0, fl, 2'd0, 2'd2, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, o));
    exp_q.push_back(pack(4'd1, fl, 2'd0, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o));
    n = 2;
    if (o == 2'b10) begin
      exp_q.push_back(pack(4'd9, fl, 2'd0, 2'd1, 1'b0, 2'd2, 1'b0, ok, 1'b0, 1'b0, 1'b0, o));
      n = 3;
    end else if (o == 2'b01) begin
      exp_q.push_back(pack(4'd2, fl, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o));
      if (f[0]) begin
        exp_q.push_back(pack(4'd3, fl, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o));
        exp_q.push_back(pack(4'd4, fl, 2'd0, 2'd0, 1'b0, 2'd1, 1'b0, ok && wr15, 1'b0, 1'b0, ok, o));
        n = 5;
      end else begin
        exp_q.push_back(pack(4'd5, fl, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, ok, 1'b0, o));
        n = 4;
      end
    end else if (o == 2'b00) begin
      cmp   = (cmd == 4'b1010);
      known = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
      arith = cmd inside {4'b0100, 4'b0010, 4'b1010};
      s     = f[0] || cmp;
      case (cmd)
        4'b0010, 4'b1010: ctl = 2'd1;
        4'b0000:          ctl = 2'd2;
        4'b1100:          ctl = 2'd3;
        default:          ctl = 2'd0;
      endcase
      exp_q.push_back(pack(f[5] ? 4'd7 : 4'd6, fl, ctl, f[5] ? 2'd1 : 2'd0, 1'b0, 2'd0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o));
      nf = fl;
      if (ok && s) nf[3:2] = af[3:2];
      if (ok && s && arith) nf[1:0] = af[1:0];
      m_flags = nf;
      exp_q.push_back(pack(4'd8, nf, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, ok && known && wr15,
                           1'b0, 1'b0, ok && known, o));
      n = 4;
    end
  endtask

  // Called just after a rising edge with the DUT sitting in FETCH.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af);
    int n;
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
    act_q.delete();
    model_instr(c, o, f, r, af, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  logic [W-1:0] cmp_e, cmp_a;
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      cmp_a = dut_vec;
      act_q.push_back(cmp_a);
      checks++;
      if (cmp_a !== cmp_e) begin
        errors++;
        $display("FAIL ctrl_vec state=%0d: got %h expected %h", cmp_e[23:20], cmp_a, cmp_e);
      end
    end
  end

  logic [W-1:0] a, b;
  logic [3:0]   rc, rr, raf;
  logic [1:0]   ro;
  logic [5:0]   rf;

  initial begin
    #12;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'hF);       // ADD reg
    chk("add_states", {act_q[0][23:20], act_q[1][23:20], act_q[2][23:20], act_q[3][23:20]}, 16'h0168);
    a = act_q[2]; chk("add_aluctl", a[15:14], 2'b00);
    a = act_q[3]; chk("add_regw", a[4], 1'b1); chk("add_flags", a[19:16], 4'b0000);

    run_instr(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100);    // SUBS
    a = act_q[3]; chk("subs_flags", a[19:16], 4'b0100);
    run_instr(4'h0, 2'b00, 6'b011000, 4'd3, 4'h0);       // ORREQ
    a = act_q[3]; chk("orreq_regw", a[4], 1'b1);
    a = act_q[2]; chk("orr_aluctl", a[15:14], 2'b11);
    run_instr(4'h1, 2'b00, 6'b011000, 4'd3, 4'h0);       // ORRNE
    a = act_q[3]; chk("orrne_regw", a[4], 1'b0);

    run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b1001);    // CMP
    a = act_q[3]; chk("cmp_flags", a[19:16], 4'b1001); chk("cmp_regw", a[4], 1'b0);
    run_instr(4'hB, 2'b10, 6'b000000, 4'd0, 4'h0);       // BLT: N==V here, not taken
    a = act_q[2]; chk("blt_state", a[23:20], 4'd9); chk("blt_pcw", a[7], 1'b0);
    run_instr(4'hA, 2'b10, 6'b000000, 4'd0, 4'h0);       // BGE: taken
    a = act_q[2]; chk("bge_pcw", a[7], 1'b1);

    run_instr(4'hE, 2'b01, 6'b000001, 4'd3, 4'h0);       // LDR
    chk("ldr_states", {act_q[0][23:20], act_q[1][23:20], act_q[2][23:20], act_q[3][23:20],
                       act_q[4][23:20]}, 20'h01234);
    a = act_q[3]; chk("ldr_adrsrc", a[8], 1'b1);
    a = act_q[4]; chk("ldr_wb", {a[10:9], a[4]}, 3'b011);
    run_instr(4'hE, 2'b01, 6'b000000, 4'd3, 4'h0);       // STR
    a = act_q[3]; b = act_q[2];
    chk("str_memw", {a[23:20], a[5], b[5]}, 6'b0101_1_0);

    run_instr(4'hE, 2'b11, 6'b001000, 4'd1, 4'h0);       // undefined
    a = act_q[1]; chk("undef_writes", {a[5], a[4]}, 2'b00);
    run_instr(4'hF, 2'b00, 6'b001000, 4'd1, 4'h0);       // never-ADD
    a = act_q[3]; chk("nv_regw", a[4], 1'b0);
    run_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'h0);      // ADD to PC
    a = act_q[3]; chk("add_pc_pcw", a[7], 1'b1);

    // Reset in the middle of a store after loading nonzero flags.
    run_instr(4'hE, 2'b00, 6'b000101, 4'd2, 4'hF);
    Cond = 4'hE; Op = 2'b01; Funct = 6'b000000; Rd = 4'd2;
    repeat (3) @(posedge clk); #1;
    chk("pre_rst_state", {State, MemWrite, Flags}, {4'd5, 1'b1, 4'hF});
    rst_n = 1'b0; #1;
    chk("rst_enables", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'b0000);
    chk("rst_state_flags", {State, Flags}, 8'h00);
    chk("rst_mux", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, {1'b0, 1'b1, 2'd2, 2'd2});
    @(posedge clk); #1;
    chk("rst_hold_enables", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_flags = 4'b0000;
    run_instr(4'hE, 2'b00, 6'b001000, 4'd4, 4'h0);
    a = act_q[0]; chk("post_rst_fetch", {a[23:20], a[7], a[6]}, 6'b0000_1_1);

    for (int i = 0; i < 300; i++) begin
      rc  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) rc = 4'hE;
      ro  = 2'($urandom_range(0, 3));
      rf  = 6'($urandom_range(0, 63));
      rr  = 4'($urandom_range(0, 15));
      raf = 4'($urandom_range(0, 15));
      run_instr(rc, ro, rf, rr, raf);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
